sum7seg_scan: RTL



---
 rtl/sum7seg_pkg.sv | 70 +++++++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/sum7seg_scan.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sum7seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum7seg_pkg
// Description : Shared definitions for the sum/difference 7-segment display.
//               Holds active-low segment glyphs (bit order a..g, index 0 = a),
//               the controller state encoding, the helper that sizes the BCD
//               field and the digit-to-glyph decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sum7seg_pkg;

  // Active-low glyphs; the leftmost literal bit lands in index 0 (segment a).
  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_E     = 7'b0110000;

  // Controller states: sample operands, run the converter, publish result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Number of decimal digits needed to print 2^m - 1 (m up to 63).
  function automatic int nbcd_of(input int m);
    logic [63:0] v;
    int          n;
    v = (64'd1 << m) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  // BCD digit to glyph; non-decimal codes render blank.
  function automatic logic [0:6] seg_of(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage : sum7seg_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter. One
//               iteration per clock: every BCD nibble >= 5 gets +3, then the
//               whole {bcd, bin} register shifts left by one. M iterations
//               convert an M-bit value.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset (aborts conversion)
//               start_i  - begin a conversion; ignored while busy_o is high
//               bin_i    - binary value, captured on the accepted start
//               busy_o   - high while iterations are running
//               done_o   - one-cycle pulse in the cycle whose closing edge
//                          performs the final iteration; bcd_o is valid from
//                          the following cycle until the next start
//               bcd_o    - NBCD packed BCD digits, digit 0 in bits [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int M    = 9,
  parameter int NBCD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [M-1:0]        bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*NBCD-1:0]   bcd_o
);

  localparam int SW = 4*NBCD + M;
  localparam int CW = $clog2(M + 1);

  logic [SW-1:0] sr_q;
  logic [SW-1:0] adj;
  logic [SW-1:0] sr_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  // Add-3 correction on every BCD nibble, applied before the shift.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < NBCD; i++) begin
      if (sr_q[M + 4*i +: 4] >= 4'd5) begin
        adj[M + 4*i +: 4] = sr_q[M + 4*i +: 4] + 4'd3;
      end
    end
    sr_d = adj << 1;
  end

  assign done_o = busy_q && (cnt_q == CW'(M - 1));
  assign busy_o = busy_q;
  assign bcd_o  = sr_q[SW-1 -: 4*NBCD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        sr_q   <= {{(4*NBCD){1'b0}}, bin_i};
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/sum7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sum7seg_scan
// Description : Computes A+B or |A-B| with sign on WIDTH-bit unsigned
//               operands, converts the magnitude to BCD sequentially and shows
//               it on a DIGITS-wide multiplexed common-anode display. The
//               leftmost digit carries the sign, or 'E' on overflow. Leading
//               zeros are blanked; the units digit is always lit.
// Ports       : CLK_50  - system clock
//               rst     - asynchronous active-high reset
//               A, B    - unsigned operands
//               Sel     - 0: A+B, 1: A-B
//               SSeg    - active-low segments a..g, SSeg[0] = a (registered)
//               an      - active-low one-hot anodes, an[0] = units digit
//               ovf     - result needs more than DIGITS-1 decimal digits
//               busy    - conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sum7seg_scan
  import sum7seg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              CLK_50,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Sel,
  output logic [0:6]        SSeg,
  output logic [DIGITS-1:0] an,
  output logic              ovf,
  output logic              busy
);

  localparam int M     = WIDTH + 1;
  localparam int NBCD  = nbcd_of(M);
  // BCD field widened so every displayed digit position has a source nibble.
  localparam int NX    = (NBCD > DIGITS - 1) ? NBCD : DIGITS - 1;
  localparam int XW    = 4 * NX;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  // --------------------------------------------------------------------------
  // Arithmetic: magnitude and sign of the selected operation
  // --------------------------------------------------------------------------
  logic [M-1:0] mag;
  logic         neg;

  always_comb begin
    mag = '0;
    neg = 1'b0;
    if (!Sel) begin
      mag = {1'b0, A} + {1'b0, B};
    end else if (A >= B) begin
      mag = {1'b0, A - B};
    end else begin
      mag = {1'b0, B - A};
      neg = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Converter
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic [4*NBCD-1:0] bcd_w;

  assign conv_start = (state_q == ST_IDLE) && !conv_busy;

  bin2bcd_seq #(
    .M    (M),
    .NBCD (NBCD)
  ) u_bin2bcd (
    .clk     (CLK_50),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (mag),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd_w)
  );

  // --------------------------------------------------------------------------
  // Overflow detection and glyph selection for the next display image
  // --------------------------------------------------------------------------
  logic [XW-1:0] bcd_ext;
  logic [0:6]    disp_d [DIGITS];
  logic [0:6]    disp_q [DIGITS];
  logic          ovf_d;
  logic          neg_q;   // sign captured with the operands being converted
  logic          lead;
  logic [3:0]    dig;

  assign bcd_ext = XW'(bcd_w);

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      disp_d[i] = SEG_BLANK;
    end
    ovf_d = 1'b0;
    lead  = 1'b1;
    dig   = '0;

    // Any nonzero digit beyond the numeric field means it cannot be shown.
    for (int i = DIGITS - 1; i < NX; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) begin
        ovf_d = 1'b1;
      end
    end

    if (ovf_d) begin
      disp_d[DIGITS-1] = SEG_E;
    end else begin
      disp_d[DIGITS-1] = neg_q ? SEG_MINUS : SEG_BLANK;
      // Walk from the most significant numeric digit down; blank zeros until
      // the first nonzero digit, but never blank the units position.
      for (int i = DIGITS - 2; i >= 0; i--) begin
        dig = bcd_ext[4*i +: 4];
        if (lead && (dig == 4'd0) && (i != 0)) begin
          disp_d[i] = SEG_BLANK;
        end else begin
          disp_d[i] = seg_of(dig);
          lead      = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Controller: IDLE samples, CONV waits for the converter, LOAD publishes
  // --------------------------------------------------------------------------
  logic busy_q;
  logic ovf_q;

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        disp_q[i] <= SEG_BLANK;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!conv_busy) begin
            neg_q   <= neg;
            busy_q  <= 1'b1;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          // done marks the final iteration, so the BCD is ready in LOAD.
          if (conv_done) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          disp_q  <= disp_d;
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;

  // --------------------------------------------------------------------------
  // Scanning: anode and segment registers update on the same edge so the
  // glyph never lags its anode.
  // --------------------------------------------------------------------------
  logic [REF_W-1:0]  ref_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              wrap;
  logic [DIGITS-1:0] an_q;
  logic [0:6]        sseg_q;

  assign wrap = (ref_q == REF_W'(REFRESH_DIV - 1));

  always_comb begin
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      ref_q  <= '0;
      idx_q  <= '0;
      an_q   <= ~DIGITS'(1);
      sseg_q <= SEG_BLANK;
    end else begin
      ref_q  <= wrap ? '0 : ref_q + REF_W'(1);
      idx_q  <= idx_d;
      an_q   <= ~(DIGITS'(1) << idx_d);
      sseg_q <= disp_q[idx_d];
    end
  end

  assign an   = an_q;
  assign SSeg = sseg_q;

endmodule : sum7seg_scan
`default_nettype wire
